// File: rtl/spi_rx_deser_if.sv
// spi_rx_deser_if: the valid/ready word channel between the SPI receive
// deserializer (master side, produces words) and the downstream rx FIFO
// (slave side, consumes words).
interface spi_rx_deser_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  rx_valid_o;
  logic                  rx_ready_i;
  logic [DATA_WIDTH-1:0] rx_data_o;

  modport master (
    output rx_valid_o,
    output rx_data_o,
    input  rx_ready_i
  );

  modport slave (
    input  rx_valid_o,
    input  rx_data_o,
    output rx_ready_i
  );
endinterface

// File: rtl/spi_rx_deser.sv
// spi_rx_deser: SPI master receive-side deserializer.
// Samples MISO on the capture edge selected by the latched CPOL/CPHA, builds
// an 8/16/24/32-bit word MSB- or LSB-first, and offers each completed word to
// a one-entry valid/ready holding register. A completed word that finds the
// holding register full (and not being drained) is dropped and flagged on
// overrun_o.
// Optional build macro SPI_RX_OVR_CNT_EN: adds ovr_clr_i / ovr_cnt_o, an
// 8-bit saturating count of overrun pulses with synchronous clear.
module spi_rx_deser #(
  parameter int DATA_WIDTH = 32
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       st_i,
  input  logic       abort_i,
  input  logic       cpol_i,
  input  logic       cpha_i,
  input  logic       lsb_i,
  input  logic [1:0] dtb_i,
  input  logic       pos_edge_i,
  input  logic       neg_edge_i,
  input  logic       spi_miso_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       overrun_o,
  spi_rx_deser_if.master rx_if
`ifdef SPI_RX_OVR_CNT_EN
  ,
  input  logic       ovr_clr_i,
  output logic [7:0] ovr_cnt_o
`endif
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Number of bits in a word for a given dtb code: 8, 16, 24 or 32.
  function automatic logic [5:0] f_word_bits(input logic [1:0] dtb);
    return {1'b0, dtb, 3'b000} + 6'd8;
  endfunction

  state_t                r_state;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_ovr;
  logic                  r_cpol;
  logic                  r_cpha;
  logic                  r_lsb;
  logic [5:0]            r_cnt;
  logic [4:0]            r_idx;
  logic [DATA_WIDTH-1:0] r_sr;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;

  logic                  w_smp;
  logic                  w_last;
  logic                  w_load;
  logic [DATA_WIDTH-1:0] w_sr_next;

  assign busy_o           = r_busy;
  assign done_o           = r_done;
  assign overrun_o        = r_ovr;
  assign rx_if.rx_valid_o = r_valid;
  assign rx_if.rx_data_o  = r_data;

  // Capture strobe, next shift-register value and holding-register load decision.
  always_comb begin
    w_smp     = (r_cpol ^ r_cpha) ? neg_edge_i : pos_edge_i;
    w_sr_next = r_sr;
    if (r_lsb) begin
      w_sr_next[r_idx] = spi_miso_i;
    end else begin
      w_sr_next = {r_sr[DATA_WIDTH-2:0], spi_miso_i};
    end
    // Final capture of a word; abort in the same cycle suppresses it.
    w_last = (r_state == ST_SHIFT) && w_smp && !abort_i && (r_cnt == 6'd1);
    w_load = w_last && (!r_valid || rx_if.rx_ready_i);
  end

  // Transfer FSM: start, per-bit capture, completion/abort and pulse outputs.
  // dtb is consumed only at start (into r_cnt), so it needs no latch of its own.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ovr   <= 1'b0;
      r_cpol  <= 1'b0;
      r_cpha  <= 1'b0;
      r_lsb   <= 1'b0;
      r_cnt   <= 6'd0;
      r_idx   <= 5'd0;
      r_sr    <= {DATA_WIDTH{1'b0}};
    end else begin
      r_done <= 1'b0;
      r_ovr  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (st_i) begin
            r_state <= ST_SHIFT;
            r_busy  <= 1'b1;
            r_cpol  <= cpol_i;
            r_cpha  <= cpha_i;
            r_lsb   <= lsb_i;
            r_cnt   <= f_word_bits(dtb_i);
            r_idx   <= 5'd0;
            r_sr    <= {DATA_WIDTH{1'b0}};
          end
        end
        ST_SHIFT: begin
          if (abort_i) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= 6'd0;
          end else if (w_smp) begin
            r_sr  <= w_sr_next;
            r_cnt <= r_cnt - 6'd1;
            // idx stops at N-1 so it never wraps on a 32-bit word.
            if (r_lsb && (r_cnt != 6'd1)) begin
              r_idx <= r_idx + 5'd1;
            end
            if (r_cnt == 6'd1) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_ovr   <= !w_load;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_cnt   <= 6'd0;
        end
      endcase
    end
  end

  // One-entry holding register: load a completed word, clear on handshake.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid <= 1'b0;
      r_data  <= {DATA_WIDTH{1'b0}};
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_data  <= w_sr_next;
    end else if (r_valid && rx_if.rx_ready_i) begin
      r_valid <= 1'b0;
    end
  end

`ifdef SPI_RX_OVR_CNT_EN
  logic [7:0] r_ovr_cnt;
  assign ovr_cnt_o = r_ovr_cnt;

  // Saturating overrun counter; a clear beats a same-cycle increment.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ovr_cnt <= 8'd0;
    end else if (ovr_clr_i) begin
      r_ovr_cnt <= 8'd0;
    end else if (r_ovr && (r_ovr_cnt != 8'd255)) begin
      r_ovr_cnt <= r_ovr_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_spi_rx_deser.sv
// tb_spi_rx_deser: self-checking bench for spi_rx_deser. The reference model
// treats a transfer as "word value, length, bit order, ready at completion"
// and tracks the holding register as a plain valid/data pair.
module tb_spi_rx_deser;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       st_i;
  logic       abort_i;
  logic       cpol_i;
  logic       cpha_i;
  logic       lsb_i;
  logic [1:0] dtb_i;
  logic       pos_edge_i;
  logic       neg_edge_i;
  logic       spi_miso_i;
  logic       busy_o;
  logic       done_o;
  logic       overrun_o;
`ifdef SPI_RX_OVR_CNT_EN
  logic       ovr_clr_i;
  logic [7:0] ovr_cnt_o;
`endif

  spi_rx_deser_if #(.DATA_WIDTH(32)) rx_if ();

  spi_rx_deser #(.DATA_WIDTH(32)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .st_i       (st_i),
    .abort_i    (abort_i),
    .cpol_i     (cpol_i),
    .cpha_i     (cpha_i),
    .lsb_i      (lsb_i),
    .dtb_i      (dtb_i),
    .pos_edge_i (pos_edge_i),
    .neg_edge_i (neg_edge_i),
    .spi_miso_i (spi_miso_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .overrun_o  (overrun_o),
    .rx_if      (rx_if)
`ifdef SPI_RX_OVR_CNT_EN
    ,
    .ovr_clr_i  (ovr_clr_i),
    .ovr_cnt_o  (ovr_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  int ovr_seen = 0;

  // Captured outputs the cycle after the final sampling edge.
  logic        cap_done, cap_busy, cap_valid, cap_ovr;
  logic [31:0] cap_data;

  // Reference model of the holding register.
  logic        model_valid = 1'b0;
  logic [31:0] model_data  = 32'd0;
  logic        exp_ovr     = 1'b0;

  // Count single-cycle pulses, sampled mid-cycle.
  always @(negedge clk_i) begin
    if (done_o === 1'b1) done_cnt++;
    if (overrun_o === 1'b1) ovr_seen++;
  end

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic model_complete(input logic [31:0] val, input int n, input bit rdy);
    logic [31:0] word;
    word = (n == 32) ? val : (val % (32'd1 << n));
    if (!model_valid || rdy) begin
      model_valid = 1'b1;
      model_data  = word;
      exp_ovr     = 1'b0;
    end else begin
      exp_ovr = 1'b1;
    end
  endtask

  task automatic drain;
    rx_if.rx_ready_i = 1'b1;
    tick();
    rx_if.rx_ready_i = 1'b0;
    model_valid = 1'b0;
  endtask

  // Pulse st_i (with a coincident, to-be-ignored strobe pair), then scramble config.
  task automatic start_xfer(input logic cpol, input logic cpha, input logic lsb, input logic [1:0] dtb);
    cpol_i = cpol; cpha_i = cpha; lsb_i = lsb; dtb_i = dtb;
    st_i = 1'b1; pos_edge_i = 1'b1; neg_edge_i = 1'b1;
    tick();
    st_i = 1'b0; pos_edge_i = 1'b0; neg_edge_i = 1'b0;
    cpol_i = 1'($urandom); cpha_i = 1'($urandom); lsb_i = 1'($urandom); dtb_i = 2'($urandom);
  endtask

  // Drive nsend bits: per bit a leading SCK edge then a trailing one.
  task automatic send_bits(input logic [31:0] val, input int n, input logic cpol, input logic cpha,
                           input logic lsb, input int nsend, input bit ready_last, input bit st_mid,
                           input bit abort_last, input bit clr_on_done);
    for (int b = 0; b < nsend; b++) begin
      spi_miso_i = lsb ? val[b] : val[n-1-b];
      if (st_mid && b == 3) begin
        st_i = 1'b1; cpol_i = 1'($urandom); cpha_i = 1'($urandom); lsb_i = 1'($urandom); dtb_i = 2'($urandom);
      end
      tick();
      st_i = 1'b0;
      for (int ph = 0; ph < 2; ph++) begin
        logic is_last;
        is_last = (ph == int'(cpha)) && (b == n - 1);
        pos_edge_i = (ph == 0) ? !cpol : cpol;
        neg_edge_i = !pos_edge_i;
        if (is_last && ready_last) rx_if.rx_ready_i = 1'b1;
        if (is_last && abort_last) abort_i = 1'b1;
        tick();
        pos_edge_i = 1'b0; neg_edge_i = 1'b0; rx_if.rx_ready_i = 1'b0; abort_i = 1'b0;
        if (is_last) begin
          cap_done = done_o; cap_busy = busy_o; cap_valid = rx_if.rx_valid_o;
          cap_ovr = overrun_o; cap_data = rx_if.rx_data_o;
`ifdef SPI_RX_OVR_CNT_EN
          ovr_clr_i = clr_on_done;
`endif
        end
        tick();
`ifdef SPI_RX_OVR_CNT_EN
        ovr_clr_i = 1'b0;
`endif
      end
    end
  endtask

  task automatic do_word(input logic [31:0] val, input logic [1:0] dtb, input logic cpol, input logic cpha,
                         input logic lsb, input bit ready_last, input bit st_mid, input bit abort_last,
                         input bit clr_on_done);
    int n;
    n = 8 * (int'(dtb) + 1);
    done_cnt = 0;
    start_xfer(cpol, cpha, lsb, dtb);
    send_bits(val, n, cpol, cpha, lsb, n, ready_last, st_mid, abort_last, clr_on_done);
    if (!abort_last) model_complete(val, n, ready_last);
  endtask

  task automatic test_reset;
    rst_i = 1'b1; st_i = 1'b0; abort_i = 1'b0; cpol_i = 1'b0; cpha_i = 1'b0; lsb_i = 1'b0;
    dtb_i = 2'b00; pos_edge_i = 1'b0; neg_edge_i = 1'b0; spi_miso_i = 1'b0; rx_if.rx_ready_i = 1'b0;
`ifdef SPI_RX_OVR_CNT_EN
    ovr_clr_i = 1'b0;
`endif
    tick(); tick();
    n_tests++;
    if ({busy_o, done_o, overrun_o, rx_if.rx_valid_o} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: busy/done/ovr/valid=%b required 0000", {busy_o, done_o, overrun_o, rx_if.rx_valid_o});
    end
    n_tests++;
    if (rx_if.rx_data_o !== 32'd0) begin
      n_fail++; $display("FAIL reset_data: got %h required 00000000", rx_if.rx_data_o);
    end
`ifdef SPI_RX_OVR_CNT_EN
    n_tests++;
    if (ovr_cnt_o !== 8'd0) begin
      n_fail++; $display("FAIL reset_ovr_cnt: got %0d required 0", ovr_cnt_o);
    end
`endif
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_mode0_msb;
    drain();
    do_word(32'h0000_00A5, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if ({cap_done, cap_busy, cap_valid, cap_ovr} !== 4'b1010 || cap_data !== 32'h0000_00A5) begin
      n_fail++; $display("FAIL mode0_a5: done/busy/valid/ovr=%b data=%h required 1010 000000a5", {cap_done, cap_busy, cap_valid, cap_ovr}, cap_data);
    end
    n_tests++;
    if (done_cnt !== 1) begin
      n_fail++; $display("FAIL mode0_done_pulse: got %0d pulses required 1", done_cnt);
    end
    drain();
    n_tests++;
    if (rx_if.rx_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL mode0_handshake: valid=%b required 0", rx_if.rx_valid_o);
    end
  endtask

  task automatic test_mode3_lsb;
    drain();
    do_word(32'h1234_5678, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if ({cap_done, cap_valid} !== 2'b11 || cap_data !== model_data) begin
      n_fail++; $display("FAIL mode3_lsb: done/valid=%b data=%h required 11 %h", {cap_done, cap_valid}, cap_data, model_data);
    end
  endtask

  task automatic test_mode12;
    for (int m = 1; m <= 2; m++) begin
      logic cpol, cpha;
      cpol = (m == 2); cpha = (m == 1);
      drain();
      do_word(32'h0000_BEEF, 2'b01, cpol, cpha, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      n_tests++;
      if ({cap_done, cap_valid} !== 2'b11 || cap_data !== 32'h0000_BEEF) begin
        n_fail++; $display("FAIL mode%0d_beef: done/valid=%b data=%h required 11 0000beef", m, {cap_done, cap_valid}, cap_data);
      end
      // Rising-edge-only stimulus must never complete a falling-edge word.
      done_cnt = 0;
      start_xfer(cpol, cpha, 1'b0, 2'b01);
      for (int k = 0; k < 20; k++) begin
        spi_miso_i = 1'($urandom);
        pos_edge_i = 1'b1; tick(); pos_edge_i = 1'b0; tick();
      end
      n_tests++;
      if (busy_o !== 1'b1 || done_cnt !== 0) begin
        n_fail++; $display("FAIL mode%0d_rise_only: busy=%b done pulses=%0d required 1 0", m, busy_o, done_cnt);
      end
      abort_i = 1'b1; tick(); abort_i = 1'b0;
    end
  endtask

  task automatic test_random;
    int bad;
    bad = 0;
    for (int i = 0; i < 24; i++) begin
      logic [31:0] val;
      logic [1:0]  dtb;
      logic        cpol, cpha, lsb;
      val = $urandom; dtb = 2'($urandom); cpol = 1'($urandom); cpha = 1'($urandom); lsb = 1'($urandom);
      if ($urandom_range(0, 1) == 0) drain();
      for (int k = 0; k < 3; k++) begin
        pos_edge_i = 1'($urandom); neg_edge_i = 1'($urandom); spi_miso_i = 1'($urandom);
        tick();
      end
      pos_edge_i = 1'b0; neg_edge_i = 1'b0;
      do_word(val, dtb, cpol, cpha, lsb, 1'($urandom), 1'($urandom), 1'b0, 1'b0);
      n_tests++;
      if ({cap_done, cap_busy, cap_valid, cap_ovr} !== {3'b101, exp_ovr} || cap_data !== model_data || done_cnt !== 1) begin
        n_fail++; bad++;
        $display("FAIL random_%0d: done/busy/valid/ovr=%b data=%h pulses=%0d required %b %h 1",
                 i, {cap_done, cap_busy, cap_valid, cap_ovr}, cap_data, done_cnt, {3'b101, exp_ovr}, model_data);
      end
    end
  endtask

  task automatic test_overrun;
    drain();
    ovr_seen = 0;
    do_word(32'h11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_word(32'h22, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if ({cap_done, cap_valid, cap_ovr} !== {2'b11, exp_ovr} || cap_data !== 32'h11 || ovr_seen !== 1) begin
      n_fail++; $display("FAIL overrun_drop: done/valid/ovr=%b data=%h pulses=%0d required 111 00000011 1",
                         {cap_done, cap_valid, cap_ovr}, cap_data, ovr_seen);
    end
`ifdef SPI_RX_OVR_CNT_EN
    n_tests++;
    if (ovr_cnt_o !== 8'd1) begin
      n_fail++; $display("FAIL ovr_cnt_one: got %0d required 1", ovr_cnt_o);
    end
    for (int i = 0; i < 259; i++) do_word($urandom, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (ovr_cnt_o !== 8'd255 || ovr_seen !== 260) begin
      n_fail++; $display("FAIL ovr_cnt_sat: got %0d pulses=%0d required 255 260", ovr_cnt_o, ovr_seen);
    end
    do_word(32'h33, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    n_tests++;
    if (ovr_cnt_o !== 8'd0) begin
      n_fail++; $display("FAIL ovr_clr_priority: got %0d required 0", ovr_cnt_o);
    end
    do_word(32'h44, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (ovr_cnt_o !== 8'd1) begin
      n_fail++; $display("FAIL ovr_cnt_after_clr: got %0d required 1", ovr_cnt_o);
    end
`else
    for (int i = 0; i < 3; i++) do_word($urandom, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (ovr_seen !== 4 || rx_if.rx_data_o !== 32'h11) begin
      n_fail++; $display("FAIL overrun_repeat: pulses=%0d data=%h required 4 00000011", ovr_seen, rx_if.rx_data_o);
    end
`endif
    ovr_seen = 0;
    do_word(32'h22, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if ({cap_valid, cap_ovr} !== {1'b1, exp_ovr} || cap_data !== 32'h22 || ovr_seen !== 0) begin
      n_fail++; $display("FAIL ready_on_completion: valid/ovr=%b data=%h pulses=%0d required 10 00000022 0",
                         {cap_valid, cap_ovr}, cap_data, ovr_seen);
    end
  endtask

  task automatic test_abort;
    drain();
    do_word(32'h5A, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    done_cnt = 0; ovr_seen = 0;
    start_xfer(1'b0, 1'b0, 1'b0, 2'b00);
    send_bits(32'hFF, 8, 1'b0, 1'b0, 1'b0, 5, 1'b0, 1'b0, 1'b0, 1'b0);
    abort_i = 1'b1; tick(); abort_i = 1'b0;
    n_tests++;
    if (busy_o !== 1'b0 || done_cnt !== 0 || rx_if.rx_valid_o !== 1'b1 || rx_if.rx_data_o !== 32'h5A) begin
      n_fail++; $display("FAIL abort_partial: busy=%b pulses=%0d valid=%b data=%h required 0 0 1 0000005a",
                         busy_o, done_cnt, rx_if.rx_valid_o, rx_if.rx_data_o);
    end
    do_word(32'h77, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    n_tests++;
    if ({cap_done, cap_busy, cap_ovr} !== 3'b000 || done_cnt !== 0 || ovr_seen !== 0 || cap_data !== 32'h5A) begin
      n_fail++; $display("FAIL abort_vs_complete: done/busy/ovr=%b pulses=%0d/%0d data=%h required 000 0/0 0000005a",
                         {cap_done, cap_busy, cap_ovr}, done_cnt, ovr_seen, cap_data);
    end
    drain();
    do_word(32'h3C, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    n_tests++;
    if ({cap_done, cap_valid} !== 2'b11 || cap_data !== 32'h3C || done_cnt !== 1) begin
      n_fail++; $display("FAIL after_abort_3c: done/valid=%b data=%h pulses=%0d required 11 0000003c 1",
                         {cap_done, cap_valid}, cap_data, done_cnt);
    end
  endtask

  task automatic test_rst_mid;
    do_word(32'h99, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    done_cnt = 0;
    start_xfer(1'b0, 1'b0, 1'b0, 2'b00);
    send_bits(32'h81, 8, 1'b0, 1'b0, 1'b0, 4, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 rst_i = 1'b1;
    #1;
    n_tests++;
    if ({busy_o, done_o, overrun_o, rx_if.rx_valid_o} !== 4'b0000 || rx_if.rx_data_o !== 32'd0) begin
      n_fail++; $display("FAIL rst_mid_async: busy/done/ovr/valid=%b data=%h required 0000 00000000",
                         {busy_o, done_o, overrun_o, rx_if.rx_valid_o}, rx_if.rx_data_o);
    end
    tick();
    rst_i = 1'b0;
    model_valid = 1'b0;
    tick();
    n_tests++;
    if (done_cnt !== 0 || rx_if.rx_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_no_word: pulses=%0d valid=%b required 0 0", done_cnt, rx_if.rx_valid_o);
    end
    do_word(32'h81, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if ({cap_done, cap_valid} !== 2'b11 || cap_data !== 32'h81) begin
      n_fail++; $display("FAIL after_rst_81: done/valid=%b data=%h required 11 00000081", {cap_done, cap_valid}, cap_data);
    end
  endtask

  initial begin
    test_reset();
    test_mode0_msb();
    test_mode3_lsb();
    test_mode12();
    test_random();
    test_overrun();
    test_abort();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
